// File: rtl/hdmi_pattern_gen.sv
// Video timing generator and test-pattern source for the HDMI path.
// Counter state (h,v) is turned into registered den/hsync/vsync/pixel_data one clock later.
module hdmi_pattern_gen #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1
) (
   input  logic        clk_pixel,
   input  logic        sys_nrst,
   input  logic        pattern_en,
   input  logic [1:0]  mode_sel,
   input  logic [23:0] solid_rgb,
   output logic        den,
   output logic        hsync,
   output logic        vsync,
   output logic [23:0] pixel_data,
   output logic        frame_start,
   output logic [15:0] frame_cnt
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW      = $clog2(H_TOTAL);
   localparam int VW      = $clog2(V_TOTAL);
   localparam int BAR_W   = H_ACTIVE / 8;

   localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
   localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
   localparam logic [31:0]   H_ACT_L  = 32'(H_ACTIVE);
   localparam logic [31:0]   V_ACT_L  = 32'(V_ACTIVE);
   localparam logic [31:0]   HS_BEG_L = 32'(H_ACTIVE + H_FP);
   localparam logic [31:0]   HS_END_L = 32'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [31:0]   VS_BEG_L = 32'(V_ACTIVE + V_FP);
   localparam logic [31:0]   VS_END_L = 32'(V_ACTIVE + V_FP + V_SYNC);

   logic [HW-1:0] r_h;
   logic [VW-1:0] r_v;
   logic [15:0]   r_frame_cnt;
   logic          r_started;
   logic [1:0]    r_mode;
   logic          r_en;
   logic [23:0]   r_solid;
   logic          r_den;
   logic          r_hs;
   logic          r_vs;
   logic          r_fs;
   logic [23:0]   r_pix;

   logic [31:0]   w_h32;
   logic [31:0]   w_v32;
   logic          w_origin;
   logic          w_h_last;
   logic          w_v_last;
   logic [1:0]    w_mode;
   logic          w_en;
   logic [23:0]   w_solid;
   logic          w_active;
   logic          w_hs_act;
   logic          w_vs_act;
   logic [6:0]    w_bar_ge;
   logic [2:0]    w_bar_idx;
   logic [23:0]   w_bar_rgb;
   logic [7:0]    w_grad;
   logic [23:0]   w_pat;
   logic [23:0]   w_pix_next;

   assign w_h32    = 32'(r_h);
   assign w_v32    = 32'(r_v);
   assign w_origin = (r_h == '0) && (r_v == '0);
   assign w_h_last = (r_h == H_LAST);
   assign w_v_last = (r_v == V_LAST);

   // The first pixel of a frame must already see the freshly sampled controls.
   assign w_mode  = w_origin ? mode_sel   : r_mode;
   assign w_en    = w_origin ? pattern_en : r_en;
   assign w_solid = w_origin ? solid_rgb  : r_solid;

   assign w_active = (w_h32 < H_ACT_L) && (w_v32 < V_ACT_L);
   assign w_hs_act = (w_h32 >= HS_BEG_L) && (w_h32 < HS_END_L);
   assign w_vs_act = (w_v32 >= VS_BEG_L) && (w_v32 < VS_END_L);

   // Thermometer of bar boundaries; the count of set bits is the bar index.
   genvar gi;
   generate
      for (gi = 1; gi < 8; gi++) begin : g_bar_cmp
         assign w_bar_ge[gi-1] = (w_h32 >= 32'(gi * BAR_W));
      end
   endgenerate

   always_comb begin
      w_bar_idx = '0;
      for (int i = 0; i < 7; i++) begin
         w_bar_idx = w_bar_idx + {2'b00, w_bar_ge[i]};
      end
   end

   always_comb begin
      w_bar_rgb = 24'h000000;
      case (w_bar_idx)
         3'd0: w_bar_rgb = 24'hFFFFFF;
         3'd1: w_bar_rgb = 24'hFFFF00;
         3'd2: w_bar_rgb = 24'h00FFFF;
         3'd3: w_bar_rgb = 24'h00FF00;
         3'd4: w_bar_rgb = 24'hFF00FF;
         3'd5: w_bar_rgb = 24'hFF0000;
         3'd6: w_bar_rgb = 24'h0000FF;
         default: w_bar_rgb = 24'h000000;
      endcase
   end

   assign w_grad = w_h32[7:0] + r_frame_cnt[7:0];

   always_comb begin
      w_pat = 24'h000000;
      case (w_mode)
         2'd0: w_pat = w_bar_rgb;
         2'd1: w_pat = {w_grad, w_grad, w_grad};
         2'd2: w_pat = (w_h32[5] ^ w_v32[5]) ? 24'hFFFFFF : 24'h000000;
         default: w_pat = w_solid;
      endcase
   end

   assign w_pix_next = (w_active && w_en) ? w_pat : 24'h000000;

   // After reset release one edge only samples the controls, so pixel (0,0) appears at edge 2.
   always_ff @(posedge clk_pixel or negedge sys_nrst) begin
      if (!sys_nrst) begin
         r_h         <= '0;
         r_v         <= '0;
         r_frame_cnt <= '0;
         r_started   <= 1'b0;
         r_mode      <= 2'd0;
         r_en        <= 1'b0;
         r_solid     <= 24'h000000;
         r_den       <= 1'b0;
         r_hs        <= ~HS_POL;
         r_vs        <= ~VS_POL;
         r_fs        <= 1'b0;
         r_pix       <= 24'h000000;
      end else if (!r_started) begin
         r_started <= 1'b1;
         r_mode    <= mode_sel;
         r_en      <= pattern_en;
         r_solid   <= solid_rgb;
      end else begin
         r_mode  <= w_mode;
         r_en    <= w_en;
         r_solid <= w_solid;
         r_den   <= w_active;
         r_hs    <= w_hs_act ? HS_POL : ~HS_POL;
         r_vs    <= w_vs_act ? VS_POL : ~VS_POL;
         r_fs    <= w_origin;
         r_pix   <= w_pix_next;
         if (w_h_last) begin
            r_h <= '0;
            if (w_v_last) begin
               r_v         <= '0;
               r_frame_cnt <= r_frame_cnt + 16'd1;
            end else begin
               r_v <= r_v + VW'(1);
            end
         end else begin
            r_h <= r_h + HW'(1);
         end
      end
   end

   assign den         = r_den;
   assign hsync       = r_hs;
   assign vsync       = r_vs;
   assign pixel_data  = r_pix;
   assign frame_start = r_fs;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_hdmi_pattern_gen.sv
// Randomised scoreboard bench for hdmi_pattern_gen on a 24x8 raster, run on two instances
// that differ only in sync polarity.
module tb_hdmi_pattern_gen;

   localparam int H_ACTIVE = 16, H_FP = 2, H_SYNC = 3, H_BP = 3;
   localparam int V_ACTIVE = 4,  V_FP = 1, V_SYNC = 2, V_BP = 1;
   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FT = HT * VT;

   logic        clk_pixel;
   logic        sys_nrst;
   logic        pattern_en;
   logic [1:0]  mode_sel;
   logic [23:0] solid_rgb;

   logic        a_den, a_hs, a_vs, a_fs;
   logic [23:0] a_pix;
   logic [15:0] a_fcnt;
   logic        b_den, b_hs, b_vs, b_fs;
   logic [23:0] b_pix;
   logic [15:0] b_fcnt;

   hdmi_pattern_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(1'b1), .VS_POL(1'b1)
   ) dut_a (
      .clk_pixel(clk_pixel), .sys_nrst(sys_nrst), .pattern_en(pattern_en),
      .mode_sel(mode_sel), .solid_rgb(solid_rgb), .den(a_den), .hsync(a_hs),
      .vsync(a_vs), .pixel_data(a_pix), .frame_start(a_fs), .frame_cnt(a_fcnt)
   );

   hdmi_pattern_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .HS_POL(1'b0), .VS_POL(1'b0)
   ) dut_b (
      .clk_pixel(clk_pixel), .sys_nrst(sys_nrst), .pattern_en(pattern_en),
      .mode_sel(mode_sel), .solid_rgb(solid_rgb), .den(b_den), .hsync(b_hs),
      .vsync(b_vs), .pixel_data(b_pix), .frame_start(b_fs), .frame_cnt(b_fcnt)
   );

   initial begin
      clk_pixel = 1'b0;
      forever #5 clk_pixel = ~clk_pixel;
   end

   typedef struct {
      bit          den;
      bit          hs;
      bit          vs;
      bit          fs;
      logic [23:0] pix;
      logic [15:0] fcnt;
   } exp_t;

   exp_t q[$];
   exp_t m_e;
   exp_t c_e;
   int checks   = 0;
   int failures = 0;
   int k = 0;
   int m_p, m_f, m_h, m_v;
   logic [1:0]  m_mode;
   bit          m_en;
   logic [23:0] m_solid;

   function automatic logic [23:0] bar_rgb(int idx);
      case (idx)
         0: return 24'hFFFFFF;
         1: return 24'hFFFF00;
         2: return 24'h00FFFF;
         3: return 24'h00FF00;
         4: return 24'hFF00FF;
         5: return 24'hFF0000;
         6: return 24'h0000FF;
         default: return 24'h000000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         if (failures <= 30)
            $display("FAIL %s actual=%h required=%h time=%0t", name, act, req, $time);
      end
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_a_den"},  32'(a_den),  32'd0);
      chk({tag, "_a_hs"},   32'(a_hs),   32'd0);
      chk({tag, "_a_vs"},   32'(a_vs),   32'd0);
      chk({tag, "_a_pix"},  32'(a_pix),  32'd0);
      chk({tag, "_a_fs"},   32'(a_fs),   32'd0);
      chk({tag, "_a_fcnt"}, 32'(a_fcnt), 32'd0);
      chk({tag, "_b_hs"},   32'(b_hs),   32'd1);
      chk({tag, "_b_vs"},   32'(b_vs),   32'd1);
      chk({tag, "_b_den"},  32'(b_den),  32'd0);
   endtask

   // Reference model: edge k after release maps to raster position (k-2) of a 192-cycle frame.
   always @(posedge clk_pixel) begin
      if (!sys_nrst) begin
         k = 0;
      end else begin
         k++;
         m_e.den = 0; m_e.hs = 0; m_e.vs = 0; m_e.fs = 0; m_e.pix = 24'h0; m_e.fcnt = 16'h0;
         if (k >= 2) begin
            m_p = (k - 2) % FT;
            m_f = (k - 2) / FT;
            m_h = m_p % HT;
            m_v = m_p / HT;
            if (m_p == 0) begin
               m_mode  = mode_sel;
               m_en    = pattern_en;
               m_solid = solid_rgb;
            end
            m_e.den  = (m_h < H_ACTIVE) && (m_v < V_ACTIVE);
            m_e.hs   = (m_h >= H_ACTIVE + H_FP) && (m_h < H_ACTIVE + H_FP + H_SYNC);
            m_e.vs   = (m_v >= V_ACTIVE + V_FP) && (m_v < V_ACTIVE + V_FP + V_SYNC);
            m_e.fs   = (m_p == 0);
            m_e.fcnt = 16'(((k - 1) / FT) % 65536);
            if (m_e.den && m_en) begin
               case (m_mode)
                  2'd0: m_e.pix = bar_rgb(m_h / (H_ACTIVE / 8));
                  2'd1: m_e.pix = {3{8'((m_h + m_f) % 256)}};
                  2'd2: m_e.pix = (((m_h >> 5) ^ (m_v >> 5)) & 1) != 0 ? 24'hFFFFFF : 24'h0;
                  default: m_e.pix = m_solid;
               endcase
            end
         end
         q.push_back(m_e);
      end
   end

   // Monitor: every output cycle pops one expectation and checks both instances.
   always @(negedge clk_pixel) begin
      if (sys_nrst && q.size() > 0) begin
         c_e = q.pop_front();
         chk("den_a",  32'(a_den),  32'(c_e.den));
         chk("den_b",  32'(b_den),  32'(c_e.den));
         chk("hs_a",   32'(a_hs),   32'(c_e.hs));
         chk("hs_b",   32'(b_hs),   32'(!c_e.hs));
         chk("vs_a",   32'(a_vs),   32'(c_e.vs));
         chk("vs_b",   32'(b_vs),   32'(!c_e.vs));
         chk("pix_a",  32'(a_pix),  32'(c_e.pix));
         chk("pix_b",  32'(b_pix),  32'(c_e.pix));
         chk("fs_a",   32'(a_fs),   32'(c_e.fs));
         chk("fcnt_a", 32'(a_fcnt), 32'(c_e.fcnt));
         if (c_e.fs)
            $display("frame start t=%0t frame_cnt=%0d mode=%0d en=%0b solid=%h",
                     $time, c_e.fcnt, m_mode, m_en, m_solid);
      end
   end

   initial begin
      int n;
      sys_nrst   = 1'b0;
      pattern_en = 1'b1;
      mode_sel   = 2'd0;
      solid_rgb  = 24'h000000;
      repeat (3) @(posedge clk_pixel);
      #1 reset_check("rst");

      // Bars for two frames.
      @(negedge clk_pixel) sys_nrst = 1'b1;
      repeat (2 * FT + 40) @(negedge clk_pixel);

      // Mid-frame switch to solid; must wait for the next frame.
      mode_sel  = 2'd3;
      solid_rgb = 24'h123456;
      repeat (FT) @(negedge clk_pixel);
      pattern_en = 1'b0;
      repeat (FT) @(negedge clk_pixel);

      // Scrolling gradient over several frames.
      pattern_en = 1'b1;
      mode_sel   = 2'd1;
      repeat (3 * FT) @(negedge clk_pixel);

      // Randomised control changes at arbitrary points in the frame.
      for (int i = 0; i < 12; i++) begin
         repeat ($urandom_range(20, 300)) @(negedge clk_pixel);
         mode_sel   = 2'($urandom_range(0, 3));
         pattern_en = ($urandom_range(0, 3) != 0);
         solid_rgb  = 24'($urandom);
      end
      repeat (FT) @(negedge clk_pixel);

      // Reset in the middle of an active line.
      n = 0;
      do begin
         @(posedge clk_pixel);
         #2;
         n++;
      end while (!(a_den && a_h_mid()) && n < 400);
      chk("wait_active_line", 32'(a_den), 32'd1);
      sys_nrst = 1'b0;
      q.delete();
      #1 reset_check("midrst");
      repeat (3) @(negedge clk_pixel);
      reset_check("hold");
      mode_sel   = 2'd0;
      pattern_en = 1'b1;
      sys_nrst   = 1'b1;
      repeat (2 * FT + 10) @(negedge clk_pixel);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // True once the current line has been active for a few pixels, so reset lands mid-line.
   function automatic bit a_h_mid();
      return ((k - 2) % HT) > 3 && ((k - 2) % HT) < H_ACTIVE - 2;
   endfunction

endmodule
